// File: rtl/benes_net_pipe.sv
// Pipelined Benes permutation network: one switch layer plus register per stage,
// routed by a control word in cbg_benes layout loaded while the pipe is empty.
module benes_net_pipe #(
  parameter int SIZE     = 32,
  parameter int DWIDTH   = 16,
  localparam int TAGWIDTH = $clog2(SIZE),
  localparam int STAGES   = 2*TAGWIDTH-1,
  localparam int BITWIDTH = STAGES*SIZE/2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [BITWIDTH-1:0]      cfg_ctrl,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE*DWIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE*DWIDTH-1:0]   out_data,
  output logic                     busy
);

  localparam int LW   = SIZE*DWIDTH;
  localparam int OCCW = $clog2(STAGES+1);
  localparam logic [OCCW-1:0] OCC_ONE = 1;

  // Sub-network blocks at depth d are contiguous runs of SIZE>>d lanes;
  // stage k < TAGWIDTH is an input stage, the rest mirror back out.
  function automatic int stage_depth(input int k);
    return (k < TAGWIDTH) ? k : STAGES-1-k;
  endfunction

  // Position of switch p of stage k in the recursive control word, found by
  // walking from its block up through the bit-interleaved parent words.
  function automatic int ctrl_idx(input int k, input int p);
    int d, nd, h, b, i;
    d  = stage_depth(k);
    nd = SIZE >> d;
    h  = nd/2;
    b  = p / h;
    i  = (k < TAGWIDTH-1) ? (p % h) : (2*(TAGWIDTH-d)-1)*h - h + (p % h);
    for (int e = d; e > 0; e--) begin
      i  = nd + 2*i + (b % 2);
      b  = b / 2;
      nd = nd * 2;
    end
    return i;
  endfunction

  // Source lane in stage k-1's register feeding lane q of stage k:
  // unshuffle toward the middle, shuffle back out after it.
  function automatic int wire_src(input int k, input int q);
    int nd, h, base, loc, src;
    if (k < TAGWIDTH) begin
      nd = SIZE >> (k-1);
      h = nd/2; base = (q/nd)*nd; loc = q % nd;
      src = base + ((loc < h) ? 2*loc : 2*(loc-h)+1);
    end else begin
      nd = SIZE >> (STAGES-1-k);
      h = nd/2; base = (q/nd)*nd; loc = q % nd;
      src = base + (((loc % 2) == 0) ? loc/2 : h + loc/2);
    end
    return src;
  endfunction

  logic [BITWIDTH-1:0] cfg_q;
  logic [LW-1:0]       data_q    [STAGES];
  logic [LW-1:0]       stage_out [STAGES];
  logic [STAGES-1:0]   valid_q;
  logic [OCCW-1:0]     occ;
  logic en, cfg_fire, in_fire, out_fire;

  assign en        = out_ready | ~valid_q[STAGES-1];
  assign cfg_ready = (occ == '0);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign in_ready  = en & ~cfg_fire;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = valid_q[STAGES-1];
  assign out_fire  = out_valid & out_ready;
  assign out_data  = data_q[STAGES-1];
  assign busy      = (occ != '0);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [LW-1:0] sw_in;
    logic [LW-1:0] sw_out;
    for (genvar q = 0; q < SIZE; q++) begin : g_wire
      if (k == 0) begin : g_first
        assign sw_in[q*DWIDTH +: DWIDTH] = in_data[q*DWIDTH +: DWIDTH];
      end else begin : g_link
        localparam int SRC = wire_src(k, q);
        assign sw_in[q*DWIDTH +: DWIDTH] = data_q[k-1][SRC*DWIDTH +: DWIDTH];
      end
    end
    for (genvar p = 0; p < SIZE/2; p++) begin : g_switch
      localparam int CI = ctrl_idx(k, p);
      assign sw_out[2*p*DWIDTH +: DWIDTH] =
        cfg_q[CI] ? sw_in[(2*p+1)*DWIDTH +: DWIDTH] : sw_in[2*p*DWIDTH +: DWIDTH];
      assign sw_out[(2*p+1)*DWIDTH +: DWIDTH] =
        cfg_q[CI] ? sw_in[2*p*DWIDTH +: DWIDTH] : sw_in[(2*p+1)*DWIDTH +: DWIDTH];
    end
    assign stage_out[k] = sw_out;
  end

  // The whole pipe advances together, bubbles included, whenever the tail can move.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else if (en) begin
      valid_q <= {valid_q[STAGES-2:0], in_fire};
      for (int k = 0; k < STAGES; k++) data_q[k] <= stage_out[k];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occ   <= '0;
      cfg_q <= '0;
    end else begin
      if (in_fire && !out_fire)      occ <= occ + OCC_ONE;
      else if (!in_fire && out_fire) occ <= occ - OCC_ONE;
      if (cfg_fire) cfg_q <= cfg_ctrl;
    end
  end

endmodule
